wave_scanner: RTL and testbench

WAVE_SCANNER -- requirements
Module: wave_scanner

---
 rtl/wave_scanner.sv | 143 ++++++++++++++
 tb/tb_wave_scanner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_scanner.sv
// Scans a precomputed wave table once per frame, emitting WIDTH samples with a scrolling
// start phase, and requests table recomputation from the wave generator on frequency changes.
module wave_scanner #(
  parameter int unsigned WIDTH     = 1024,
  parameter int unsigned LOG_WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           freq_req,
  input  logic                 freq_req_valid,
  input  logic                 frame_start,
  input  logic [3:0]           scroll_step,
  input  logic                 wave_ready,
  input  logic [10:0]          period,
  input  logic [9:0]           wave_height,
  output logic [4:0]           freq_id,
  output logic                 new_f,
  output logic [10:0]          index,
  output logic                 sample_valid,
  output logic [LOG_WIDTH-1:0] sample_x,
  output logic [9:0]           sample_height,
  output logic                 busy,
  output logic                 frame_miss
);

  typedef enum logic [1:0] {StReq, StWait, StReady, StScan} state_e;

  localparam logic [LOG_WIDTH-1:0] XLast = LOG_WIDTH'(WIDTH - 1);

  state_e               state;
  logic [10:0]          p_reg;
  logic [10:0]          offset;
  logic [10:0]          rd;
  logic [LOG_WIDTH-1:0] x;
  logic                 pend_valid;
  logic [4:0]           pend_id;
  logic                 pipe_valid;
  logic [LOG_WIDTH-1:0] pipe_x;

  logic [11:0] step_sum;
  logic [11:0] step_wrap;
  logic [10:0] offset_next;
  logic [10:0] rd_next;
  logic        scan_start;

  // Scroll phase update; a second overflow (step larger than the table) snaps to 0.
  always_comb begin
    step_sum  = {1'b0, offset} + {8'd0, scroll_step};
    step_wrap = step_sum;
    if (step_wrap >= {1'b0, p_reg}) step_wrap = step_wrap - {1'b0, p_reg};
    if (step_wrap >= {1'b0, p_reg}) step_wrap = '0;
    offset_next = step_wrap[10:0];
  end

  always_comb begin
    rd_next = rd + 11'd1;
    if (p_reg == 11'd0 || rd == p_reg - 11'd1) rd_next = '0;
  end

  assign scan_start = (state == StReady) && !pend_valid && frame_start;
  assign index      = (state == StScan) ? rd : '0;
  assign busy       = (state != StReady);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= StWait;
      freq_id    <= '0;
      new_f      <= 1'b0;
      frame_miss <= 1'b0;
      p_reg      <= '0;
      offset     <= '0;
      rd         <= '0;
      x          <= '0;
      pend_valid <= 1'b0;
      pend_id    <= '0;
    end else begin
      new_f      <= 1'b0;
      frame_miss <= frame_start && !scan_start;

      // A request arriving on the service edge becomes the new pending one.
      if (freq_req_valid) begin
        pend_valid <= 1'b1;
        pend_id    <= freq_req;
      end else if (state == StReady && pend_valid) begin
        pend_valid <= 1'b0;
      end

      unique case (state)
        StReq: begin
          state <= StWait;
        end
        StWait: begin
          if (wave_ready) begin
            state  <= StReady;
            p_reg  <= period;
            offset <= '0;
          end
        end
        StReady: begin
          if (pend_valid) begin
            state   <= StReq;
            freq_id <= pend_id;
            new_f   <= 1'b1;
          end else if (frame_start) begin
            state  <= StScan;
            offset <= offset_next;
            rd     <= offset_next;
            x      <= '0;
          end
        end
        StScan: begin
          rd <= rd_next;
          if (x == XLast) begin
            state <= StReady;
          end else begin
            x <= x + LOG_WIDTH'(1);
          end
        end
        default: state <= StWait;
      endcase
    end
  end

  // Two-stage read pipeline: table data returns one cycle after index, then is registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_valid    <= 1'b0;
      pipe_x        <= '0;
      sample_valid  <= 1'b0;
      sample_x      <= '0;
      sample_height <= '0;
    end else begin
      pipe_valid   <= (state == StScan);
      pipe_x       <= x;
      sample_valid <= pipe_valid;
      if (pipe_valid) begin
        sample_x      <= pipe_x;
        sample_height <= wave_height;
      end
    end
  end

endmodule

// File: tb/tb_wave_scanner.sv
// Directed bench for wave_scanner: table of scan frames plus hand sequences for
// request handling, dropped frames and reset mid-scan.
module tb_wave_scanner;

  localparam int W = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  freq_req = '0;
  logic        freq_req_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  scroll_step = '0;
  logic        wave_ready = 1'b0;
  logic [10:0] period = '0;
  logic [9:0]  wave_height = '0;
  logic [4:0]  freq_id;
  logic        new_f;
  logic [10:0] index;
  logic        sample_valid;
  logic [9:0]  sample_x;
  logic [9:0]  sample_height;
  logic        busy;
  logic        frame_miss;

  int n_vec = 0;
  int n_err = 0;

  wave_scanner #(.WIDTH(W), .LOG_WIDTH(10)) dut (
    .clock          (clock),
    .reset          (reset),
    .freq_req       (freq_req),
    .freq_req_valid (freq_req_valid),
    .frame_start    (frame_start),
    .scroll_step    (scroll_step),
    .wave_ready     (wave_ready),
    .period         (period),
    .wave_height    (wave_height),
    .freq_id        (freq_id),
    .new_f          (new_f),
    .index          (index),
    .sample_valid   (sample_valid),
    .sample_x       (sample_x),
    .sample_height  (sample_height),
    .busy           (busy),
    .frame_miss     (frame_miss)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] wave_of(input int i);
    return 10'((i * 7 + 3) & 1023);
  endfunction

  // Wave table model: data for an index is returned on the following cycle.
  always @(posedge clock) wave_height <= wave_of(int'(index));

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    freq_req_valid = 1'b0;
    frame_start = 1'b0;
    wave_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_period(input int p);
    @(negedge clock);
    wave_ready = 1'b1;
    period = 11'(p);
    @(negedge clock);
    wave_ready = 1'b0;
  endtask

  task automatic pulse_req(input int id);
    @(negedge clock);
    freq_req = 5'(id);
    freq_req_valid = 1'b1;
    @(negedge clock);
    freq_req_valid = 1'b0;
  endtask

  task automatic wait_new_f(input string tag);
    int k;
    k = 0;
    while (!new_f && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk(tag, int'(new_f), 1);
  endtask

  task automatic run_frame(input string tag, input logic [3:0] step, input int p,
                           input int first, input int last);
    int n, cnt, bad, lat, idx, last_h;
    scroll_step = step;
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    chk({tag, " first_index"}, int'(index), first);
    n = 0; cnt = 0; bad = 0; lat = -1; last_h = -1;
    while (n < 1200) begin
      if (sample_valid) begin
        if (lat < 0) lat = n;
        idx = (p == 0) ? 0 : (first + cnt) % p;
        if (sample_x != cnt[9:0] || sample_height != wave_of(idx)) bad++;
        last_h = int'(sample_height);
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
      @(negedge clock);
      n++;
    end
    chk({tag, " latency"}, lat, 2);
    chk({tag, " sample_count"}, cnt, W);
    chk({tag, " bad_samples"}, bad, 0);
    chk({tag, " last_height"}, last_h, int'(wave_of(last)));
    chk({tag, " busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    int         p;
    logic [3:0] step;
    int         first;
    int         last;
  } vec_t;

  vec_t vecs[7];
  int   firsts[8];

  initial begin
    int nf_cnt, nf_id, miss_cnt, smp_cnt, sv_seen;

    vecs[0] = '{100,  4'd0,  0,  23};
    vecs[1] = '{100,  4'd9,  9,  32};
    vecs[2] = '{5,    4'd15, 0,  3};
    vecs[3] = '{0,    4'd5,  0,  0};
    vecs[4] = '{7,    4'd3,  3,  4};
    vecs[5] = '{1,    4'd1,  0,  0};
    vecs[6] = '{2000, 4'd15, 15, 1038};
    firsts = '{15, 30, 45, 60, 75, 90, 95, 4};

    // Reset state
    @(negedge clock);
    chk("rst busy", int'(busy), 1);
    chk("rst new_f", int'(new_f), 0);
    chk("rst index", int'(index), 0);
    chk("rst sample_valid", int'(sample_valid), 0);
    chk("rst frame_miss", int'(frame_miss), 0);
    chk("rst freq_id", int'(freq_id), 0);
    do_reset();

    // frame_start while waiting for the table is dropped
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    chk("wait frame_miss", int'(frame_miss), 1);
    sv_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (sample_valid) sv_seen++;
    end
    chk("wait no_scan", sv_seen, 0);
    chk("wait busy", int'(busy), 1);

    // First table fill -> READY
    load_period(100);
    chk("ready busy", int'(busy), 0);
    chk("ready new_f", int'(new_f), 0);

    // Frequency request from READY
    pulse_req(7);
    wait_new_f("req7 new_f");
    chk("req7 freq_id", int'(freq_id), 7);
    chk("req7 busy", int'(busy), 1);
    @(negedge clock);
    chk("req7 new_f_one_cycle", int'(new_f), 0);
    repeat (5) @(negedge clock);
    chk("req7 freq_id_hold", int'(freq_id), 7);
    load_period(100);
    chk("req7 ready busy", int'(busy), 0);
    chk("req7 ready freq_id", int'(freq_id), 7);

    // Table-driven frames, each from a fresh fill (offset 0)
    for (int i = 0; i < 7; i++) begin
      do_reset();
      load_period(vecs[i].p);
      run_frame($sformatf("vec%0d", i), vecs[i].step, vecs[i].p, vecs[i].first, vecs[i].last);
    end

    // Offset accumulates across frames and wraps: 95 + 9 -> 4
    do_reset();
    load_period(100);
    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("scroll%0d", i), (i < 6) ? 4'd15 : (i == 6 ? 4'd5 : 4'd9), 100,
                firsts[i], (firsts[i] + 23) % 100);
    end

    // Requests and frame_start during a scan
    do_reset();
    load_period(100);
    scroll_step = 4'd0;
    nf_cnt = 0; nf_id = -1; miss_cnt = 0; smp_cnt = 0;
    for (int n = 0; n < 1100; n++) begin
      frame_start = (n == 0 || n == 60);
      freq_req_valid = (n == 20 || n == 40);
      freq_req = (n == 20) ? 5'd3 : 5'd9;
      if (sample_valid) smp_cnt++;
      if (frame_miss) miss_cnt++;
      if (new_f) begin
        nf_cnt++;
        nf_id = int'(freq_id);
      end
      @(negedge clock);
    end
    frame_start = 1'b0;
    freq_req_valid = 1'b0;
    chk("scanreq samples", smp_cnt, W);
    chk("scanreq frame_miss", miss_cnt, 1);
    chk("scanreq new_f_count", nf_cnt, 1);
    chk("scanreq freq_id", nf_id, 9);

    // Request pending while WAIT: READY one cycle, then REQ
    do_reset();
    pulse_req(5);
    load_period(100);
    chk("waitreq ready_cycle", int'(busy), 0);
    @(negedge clock);
    chk("waitreq new_f", int'(new_f), 1);
    chk("waitreq freq_id", int'(freq_id), 5);

    // Pending request beats a simultaneous frame_start
    do_reset();
    load_period(100);
    @(negedge clock);
    freq_req = 5'd12;
    freq_req_valid = 1'b1;
    @(negedge clock);
    freq_req_valid = 1'b0;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    chk("prio new_f", int'(new_f), 1);
    chk("prio frame_miss", int'(frame_miss), 1);

    // Reset mid-scan
    do_reset();
    load_period(100);
    pulse_req(4);
    wait_new_f("midrst new_f");
    load_period(100);
    @(negedge clock);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    repeat (20) @(negedge clock);
    chk("midrst valid_before", int'(sample_valid), 1);
    chk("midrst freq_before", int'(freq_id), 4);
    #2 reset = 1'b1;
    #1;
    chk("midrst sample_valid", int'(sample_valid), 0);
    chk("midrst busy", int'(busy), 1);
    chk("midrst freq_id", int'(freq_id), 0);
    chk("midrst index", int'(index), 0);
    @(negedge clock);
    reset = 1'b0;
    sv_seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (sample_valid) sv_seen++;
    end
    chk("midrst no_more_samples", sv_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
